pwr_rail_seq: RTL and testbench

- Sequences the switched supply rails of the top-level power network: VDD1..VDD6, feeding block1..block9 instances.
- Each rail has a software "desired on" request. The block drives the rail power-switch enable and reports power-good after a programmable ramp time.
- Only one rail ramps (up or down) at a time, to bound inrush current. Pending rails are served round-robin.
- Sits beside the top netlist in the always-on domain. Drives header switch enables and the power-good status toward the PMU registers.

---
 rtl/pwr_rail_seq_pkg.sv | 18 +
 rtl/pwr_rail_seq_rr_pick.sv | 31 +++
 rtl/pwr_rail_seq.sv | 103 ++++++++++
 tb/tb_pwr_rail_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_rail_seq_pkg.sv
// Shared types for the rail sequencer: FSM state encoding, default rail count
// and the index-width helper.
package pwr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2
  } state_e;

  localparam int NUM_RAILS_DEF = 6;

  // Keeps a one-rail build at a 1-bit index instead of a zero-width bus.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwr_rail_seq_rr_pick.sv
// Combinational round-robin first-one finder: grants the first pending
// index strictly after ptr_i, wrapping from N-1 to 0.
module rr_pick
  import pwr_seq_pkg::*;
#(
  parameter int N     = NUM_RAILS_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     pend_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_o,
  output logic             vld_o
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest pending index is the last one written.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % N);
      if (pend_i[cand]) begin
        gnt_o = cand;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwr_rail_seq.sv
// Power-rail sequencer: ramps one rail at a time (up or down) over ramp_len+1
// clocks, serving pending rails round-robin. All outputs are registered.
module pwr_rail_seq
  import pwr_seq_pkg::*;
#(
  parameter int NUM_RAILS = NUM_RAILS_DEF,
  parameter int CNT_W     = 8,
  parameter int IDX_W     = idx_w(NUM_RAILS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seq_en,
  input  logic [NUM_RAILS-1:0] rail_req,
  input  logic [CNT_W-1:0]     ramp_len,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic [NUM_RAILS-1:0] rail_good,
  output logic                 busy,
  output logic [IDX_W-1:0]     active_rail
);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NUM_RAILS-1:0] en_q;
  logic [NUM_RAILS-1:0] good_q;
  logic                 busy_q;

  logic [NUM_RAILS-1:0] pending;
  logic [IDX_W-1:0]     gnt;
  logic                 gnt_vld;

  assign pending = rail_req ^ good_q;

  rr_pick #(
    .N     (NUM_RAILS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .pend_i (pending),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .vld_o  (gnt_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(NUM_RAILS - 1);
      idx_q   <= '0;
      en_q    <= '0;
      good_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seq_en && gnt_vld) begin
            ptr_q  <= gnt;
            idx_q  <= gnt;
            cnt_q  <= ramp_len;
            busy_q <= 1'b1;
            if (rail_req[gnt]) begin
              en_q[gnt] <= 1'b1;
              state_q   <= RAMP_UP;
            end else begin
              // Power-good drops first so the PMU never sees a dying rail as good.
              good_q[gnt] <= 1'b0;
              state_q     <= RAMP_DN;
            end
          end
        end
        RAMP_UP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            good_q[idx_q] <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        RAMP_DN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            en_q[idx_q] <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rail_en     = en_q;
  assign rail_good   = good_q;
  assign busy        = busy_q;
  assign active_rail = idx_q;

endmodule

// File: tb/tb_pwr_rail_seq.sv
// Bench for pwr_rail_seq: directed scenarios plus random traffic, all checked
// against a timestamp-based reference model of the sequencing rules.
module tb_pwr_rail_seq;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         seq_en;
  logic [N-1:0] rail_req;
  logic [7:0]   ramp_len;
  logic [N-1:0] rail_en;
  logic [N-1:0] rail_good;
  logic         busy;
  logic [2:0]   active_rail;

  int errors = 0;
  int checks = 0;

  pwr_rail_seq dut (
    .clk         (clk),
    .rst         (rst),
    .seq_en      (seq_en),
    .rail_req    (rail_req),
    .ramp_len    (ramp_len),
    .rail_en     (rail_en),
    .rail_good   (rail_good),
    .busy        (busy),
    .active_rail (active_rail)
  );

  always #5 clk = ~clk;

  // Reference model: a ramp is a record (rail, direction, finishing cycle).
  logic [N-1:0] m_en, m_good;
  bit           m_busy, m_dir;
  int           m_act, m_last, m_end, m_cyc;

  task automatic model_reset();
    m_en = '0; m_good = '0; m_busy = 0; m_dir = 0;
    m_act = 0; m_last = N - 1; m_end = 0; m_cyc = 0;
  endtask

  // Applies one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    logic [N-1:0] pend;
    bit found;
    int r;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (m_cyc == m_end) begin
        if (m_dir) m_good[m_act] = 1'b1;
        else       m_en[m_act]   = 1'b0;
        m_busy = 0;
      end
    end else if (seq_en) begin
      pend  = rail_req ^ m_good;
      found = 0;
      r     = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && pend[(m_last + k) % N]) begin
          found = 1;
          r     = (m_last + k) % N;
        end
      end
      if (found) begin
        m_last = r; m_act = r; m_busy = 1;
        m_end  = m_cyc + int'(ramp_len) + 1;
        m_dir  = rail_req[r];
        if (m_dir) m_en[r]   = 1'b1;
        else       m_good[r] = 1'b0;
      end
    end
    m_cyc++;
  endtask

  function automatic logic [15:0] exp_vec();
    return {m_en, m_good, logic'(m_busy), 3'(m_act)};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {rail_en, rail_good, busy, active_rail};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    seq_en = 1'b0; rail_req = '0; ramp_len = 8'd0;
    do_reset();
    checks++;
    if (obs_vec() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), 16'h0000);
    end
  endtask

  task automatic test_single_up();
    int busy_cnt = 0;
    seq_en = 1'b1; ramp_len = 8'd4; rail_req = 6'b000001;
    tick();
    checks++;
    if (rail_en !== 6'b000001 || rail_good !== 6'b000000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start got en=%b good=%b busy=%b exp en=000001 good=000000 busy=1",
               rail_en, rail_good, busy);
    end
    busy_cnt = 1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (busy) busy_cnt++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (busy_cnt != 5 || rail_good !== 6'b000001 || active_rail !== 3'd0) begin
      errors++;
      $display("FAIL single_busy_len got busy=%0d good=%b act=%0d exp busy=5 good=000001 act=0",
               busy_cnt, rail_good, active_rail);
    end
  endtask

  task automatic test_rr_burst();
    int order[$];
    logic [N-1:0] prev;
    do_reset();
    seq_en = 1'b1; ramp_len = 8'd2; rail_req = 6'b111111;
    for (int c = 0; c < 30; c++) begin
      prev = rail_en;
      tick();
      for (int i = 0; i < N; i++) if (rail_en[i] && !prev[i]) order.push_back(i);
      checks++;
      if (obs_vec() !== exp_vec() || $countones(rail_en ^ rail_good) > 1) begin
        errors++;
        $display("FAIL burst_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (order.size() != 6 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
        order[3] != 3 || order[4] != 4 || order[5] != 5) begin
      errors++;
      $display("FAIL burst_order got n=%0d exp order 0..5", order.size());
    end
    checks++;
    if (rail_good !== 6'b111111) begin
      errors++;
      $display("FAIL burst_all_good got=%b exp=111111", rail_good);
    end
  endtask

  task automatic test_power_down();
    int fall_at = -1;
    rail_req = 6'b110111; ramp_len = 8'd3;
    tick();
    checks++;
    if (rail_good !== 6'b110111 || rail_en !== 6'b111111) begin
      errors++;
      $display("FAIL pdn_start got en=%b good=%b exp en=111111 good=110111", rail_en, rail_good);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (fall_at < 0 && !rail_en[3]) fall_at = c;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pdn_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (fall_at != 4 || rail_en !== 6'b110111) begin
      errors++;
      $display("FAIL pdn_delay got fall=%0d en=%b exp fall=4 en=110111", fall_at, rail_en);
    end
  endtask

  task automatic test_toggle();
    bit saw_good = 0;
    do_reset();
    seq_en = 1'b1; ramp_len = 8'd8; rail_req = 6'b000100;
    for (int c = 0; c < 30; c++) begin
      if (c == 3) rail_req = 6'b000000;
      tick();
      if (rail_good[2]) saw_good = 1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL toggle_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (!saw_good || rail_en !== 6'b000000 || rail_good !== 6'b000000) begin
      errors++;
      $display("FAIL toggle_result got saw_good=%0d en=%b exp saw_good=1 en=000000", saw_good, rail_en);
    end
  endtask

  task automatic test_seq_en_gate();
    do_reset();
    seq_en = 1'b0; ramp_len = 8'd1; rail_req = 6'b010000;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (rail_en !== 6'b000000 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gate_hold cyc=%0d got en=%b exp en=000000", c, rail_en);
      end
    end
    seq_en = 1'b1;
    tick();
    checks++;
    if (rail_en !== 6'b010000 || active_rail !== 3'd4) begin
      errors++;
      $display("FAIL gate_release got en=%b act=%0d exp en=010000 act=4", rail_en, active_rail);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    seq_en = 1'b1; ramp_len = 8'd6; rail_req = 6'b000010;
    tick();
    rail_req = 6'b000011;
    tick();
    checks++;
    if (rail_en !== 6'b000010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got en=%b busy=%b exp en=000010 busy=1", rail_en, busy);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (rail_en !== 6'b0 || rail_good !== 6'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_async got en=%b good=%b busy=%b exp all 0", rail_en, rail_good, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rail_en !== 6'b000001 || active_rail !== 3'd0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL areset_rerun got en=%b act=%0d exp en=000001 act=0", rail_en, active_rail);
    end
  endtask

  task automatic test_random();
    do_reset();
    seq_en = 1'b1; rail_req = '0; ramp_len = 8'd0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) rail_req[$urandom_range(0, N - 1)] ^= 1'b1;
      ramp_len = 8'($urandom_range(0, 4));
      seq_en   = ($urandom_range(0, 9) != 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || (rail_good & ~rail_en) != '0 ||
          $countones(rail_en ^ rail_good) > 1) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_up();
    test_rr_burst();
    test_power_down();
    test_toggle();
    test_seq_en_gate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
